// File: rtl/mult_div_iter.sv
// rtl/mult_div_iter.sv - iterative shift-add multiplier / restoring divider with HI/LO accumulate
//
// Ports:
//   clk        rising-edge clock
//   reset      asynchronous active-low reset, clears all state
//   a, b       operands (a is also the mthi/mtlo write data)
//   op         000 mult, 001 multu, 010 div, 011 divu, 100 madd, 101 maddu, 110 msub, 111 msubu
//   start      launch op on a/b (accepted only in IDLE)
//   interrupt  suppresses start/mthi/mtlo in the same cycle
//   flush      aborts an in-flight operation, blocks a start in IDLE
//   mthi, mtlo write a into HI/LO while idle
//   busy       operation in flight (RUN or FIX)
//   done       one-cycle pulse after HI/LO take a result
//   hi, lo     architectural HI/LO registers
module mult_div_iter #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [2:0]       op,
    input  logic             start,
    input  logic             interrupt,
    input  logic             flush,
    input  logic             mthi,
    input  logic             mtlo,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    localparam int CW = $clog2(WIDTH + 1);

    typedef enum logic [1:0] {IDLE, RUN, FIX} state_t;

    // kind: 00 multiply, 01 divide, 10 accumulate, 11 subtract-accumulate
    state_t             state;
    logic [CW-1:0]      cnt;
    logic [2*WIDTH-1:0] prod;      // multiply: {partial, multiplier}; divide: {remainder, quotient}
    logic [WIDTH-1:0]   mag;       // multiplicand or divisor magnitude
    logic [WIDTH-1:0]   a_orig;    // divide-by-zero returns the untouched dividend in HI
    logic [1:0]         kind;
    logic               neg_q;     // sign of product / quotient
    logic               neg_r;     // sign of remainder (follows dividend)
    logic               b_zero;

    logic               in_div;
    logic               in_signed;
    logic [WIDTH-1:0]   abs_a;
    logic [WIDTH-1:0]   abs_b;

    always_comb begin
        in_div    = (op[2:1] == 2'b01);
        in_signed = ~op[0];
        abs_a     = (in_signed && a[WIDTH-1]) ? -a : a;
        abs_b     = (in_signed && b[WIDTH-1]) ? -b : b;
    end

    // One iteration of each algorithm; only one is committed depending on kind.
    logic [WIDTH:0]     mul_sum;
    logic [WIDTH:0]     rem_sh;
    logic [WIDTH:0]     diff;
    logic [2*WIDTH-1:0] mul_next;
    logic [2*WIDTH-1:0] div_next;

    always_comb begin
        mul_sum  = {1'b0, prod[2*WIDTH-1:WIDTH]} + (prod[0] ? {1'b0, mag} : {(WIDTH+1){1'b0}});
        mul_next = {mul_sum, prod[WIDTH-1:1]};
        rem_sh   = {prod[2*WIDTH-1:WIDTH], prod[WIDTH-1]};
        diff     = rem_sh - {1'b0, mag};
        // Borrow out of the W+1 bit subtraction means the trial went negative: restore.
        if (diff[WIDTH])
            div_next = {rem_sh[WIDTH-1:0], prod[WIDTH-2:0], 1'b0};
        else
            div_next = {diff[WIDTH-1:0], prod[WIDTH-2:0], 1'b1};
    end

    // Sign correction and HI/LO combine applied in FIX.
    logic [2*WIDTH-1:0] prod_s;
    logic [WIDTH-1:0]   quo;
    logic [WIDTH-1:0]   rem;
    logic [2*WIDTH-1:0] fix_res;

    always_comb begin
        prod_s = neg_q ? -prod : prod;
        quo    = prod[WIDTH-1:0];
        rem    = prod[2*WIDTH-1:WIDTH];
        case (kind)
            2'b00:   fix_res = prod_s;
            2'b01:   begin
                if (b_zero)
                    fix_res = {a_orig, {WIDTH{1'b1}}};
                else
                    fix_res = {(neg_r ? -rem : rem), (neg_q ? -quo : quo)};
            end
            2'b10:   fix_res = {hi, lo} + prod_s;
            default: fix_res = {hi, lo} - prod_s;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state  <= IDLE;
            cnt    <= '0;
            prod   <= '0;
            mag    <= '0;
            a_orig <= '0;
            kind   <= 2'b00;
            neg_q  <= 1'b0;
            neg_r  <= 1'b0;
            b_zero <= 1'b0;
            busy   <= 1'b0;
            done   <= 1'b0;
            hi     <= '0;
            lo     <= '0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (!interrupt) begin
                        if (mthi) hi <= a;
                        if (mtlo) lo <= a;
                    end
                    if (start && !interrupt && !flush) begin
                        mag    <= in_div ? abs_b : abs_a;
                        prod   <= {{WIDTH{1'b0}}, (in_div ? abs_a : abs_b)};
                        a_orig <= a;
                        kind   <= op[2:1];
                        neg_q  <= in_signed & (a[WIDTH-1] ^ b[WIDTH-1]);
                        neg_r  <= in_signed & a[WIDTH-1];
                        b_zero <= (b == '0);
                        cnt    <= CW'(WIDTH);
                        busy   <= 1'b1;
                        state  <= RUN;
                    end
                end
                RUN: begin
                    if (flush) begin
                        cnt   <= '0;
                        busy  <= 1'b0;
                        state <= IDLE;
                    end else begin
                        prod <= (kind == 2'b01) ? div_next : mul_next;
                        cnt  <= cnt - 1'b1;
                        if (cnt == CW'(1))
                            state <= FIX;
                    end
                end
                FIX: begin
                    busy  <= 1'b0;
                    state <= IDLE;
                    if (!flush) begin
                        {hi, lo} <= fix_res;
                        done     <= 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mult_div_iter.sv
// tb/tb_mult_div_iter.sv - scoreboard bench for mult_div_iter at WIDTH=32
module tb_mult_div_iter;

    localparam int W = 32;

    logic         clk = 1'b0;
    logic         reset = 1'b0;
    logic [W-1:0] a = '0;
    logic [W-1:0] b = '0;
    logic [2:0]   op = 3'b000;
    logic         start = 1'b0;
    logic         interrupt = 1'b0;
    logic         flush = 1'b0;
    logic         mthi = 1'b0;
    logic         mtlo = 1'b0;
    logic         busy;
    logic         done;
    logic [W-1:0] hi;
    logic [W-1:0] lo;

    mult_div_iter #(.WIDTH(W)) dut (
        .clk(clk), .reset(reset), .a(a), .b(b), .op(op), .start(start),
        .interrupt(interrupt), .flush(flush), .mthi(mthi), .mtlo(mtlo),
        .busy(busy), .done(done), .hi(hi), .lo(lo)
    );

    always #5 clk = ~clk;

    int           total = 0;
    int           bad = 0;
    int           ndone = 0;
    logic [63:0]  sb[$];
    string        lbl[$];
    logic [63:0]  exp_v;
    string        exp_n;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s: got %h required %h", name, act, req);
        end
    endtask

    // Monitor: every done pulse must match the oldest outstanding expectation.
    always @(negedge clk) begin
        if (reset && done) begin
            ndone++;
            if (sb.size() == 0) begin
                total++;
                bad++;
                $display("FAIL unexpected_done: got done=1 with hi=%h lo=%h, required no done", hi, lo);
            end else begin
                exp_v = sb.pop_front();
                exp_n = lbl.pop_front();
                chk({exp_n, " hi"}, {32'd0, hi}, {32'd0, exp_v[63:32]});
                chk({exp_n, " lo"}, {32'd0, lo}, {32'd0, exp_v[31:0]});
            end
        end
    end

    task automatic launch(input logic [2:0] o, input logic [W-1:0] x, input logic [W-1:0] y,
                          input logic wr_hi);
        @(negedge clk);
        op = o; a = x; b = y; start = 1'b1; mthi = wr_hi;
        @(negedge clk);
        start = 1'b0; mthi = 1'b0;
    endtask

    task automatic wait_idle(output int n);
        n = 0;
        while (busy && n < 100) begin
            n++;
            @(negedge clk);
        end
        if (n >= 100) begin
            total++;
            bad++;
            $display("FAIL wait_idle: busy still 1 after %0d cycles, required 0", n);
        end
    endtask

    task automatic run_op(input string name, input logic [2:0] o, input logic [W-1:0] x,
                          input logic [W-1:0] y, input logic wr_hi, input logic [63:0] e);
        int n;
        sb.push_back(e);
        lbl.push_back(name);
        launch(o, x, y, wr_hi);
        wait_idle(n);
        chk({name, " busy_cycles"}, n, 64'd33);
        @(negedge clk);
    endtask

    task automatic mt(input logic to_hi, input logic [W-1:0] v);
        @(negedge clk);
        a = v; mthi = to_hi; mtlo = ~to_hi;
        @(negedge clk);
        mthi = 1'b0; mtlo = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, total=%0d bad=%0d", total, bad);
        $fatal(1);
    end

    initial begin
        int          d0;
        int          k;
        int          n;
        logic [W-1:0] h0;
        logic [W-1:0] l0;

        #12;
        chk("reset hi", {32'd0, hi}, 64'd0);
        chk("reset lo", {32'd0, lo}, 64'd0);
        chk("reset busy", {63'd0, busy}, 64'd0);
        chk("reset done", {63'd0, done}, 64'd0);
        @(negedge clk);
        reset = 1'b1;

        d0 = ndone;
        run_op("mult_neg", 3'b000, 32'hFFFFFFFE, 32'd3, 1'b0, 64'hFFFFFFFF_FFFFFFFA);
        chk("mult_neg done_pulses", ndone - d0, 64'd1);
        run_op("multu_max", 3'b001, 32'hFFFFFFFF, 32'hFFFFFFFF, 1'b0, 64'hFFFFFFFE_00000001);
        run_op("mult_minsq", 3'b000, 32'h80000000, 32'h80000000, 1'b0, 64'h40000000_00000000);
        run_op("divu_7_2", 3'b011, 32'd7, 32'd2, 1'b0, 64'h00000001_00000003);
        run_op("div_m7_2", 3'b010, 32'hFFFFFFF9, 32'd2, 1'b0, 64'hFFFFFFFF_FFFFFFFD);
        run_op("div_7_m2", 3'b010, 32'd7, 32'hFFFFFFFE, 1'b0, 64'h00000001_FFFFFFFD);
        run_op("div_ovf", 3'b010, 32'h80000000, 32'hFFFFFFFF, 1'b0, 64'h00000000_80000000);
        run_op("divu_by0", 3'b011, 32'd5, 32'd0, 1'b0, 64'h00000005_FFFFFFFF);
        run_op("div_by0", 3'b010, 32'hFFFFFFF9, 32'd0, 1'b0, 64'hFFFFFFF9_FFFFFFFF);

        mt(1'b1, 32'd0);
        mt(1'b0, 32'hFFFFFFFF);
        chk("mthi", {32'd0, hi}, 64'd0);
        chk("mtlo", {32'd0, lo}, 64'h00000000_FFFFFFFF);
        run_op("maddu_carry", 3'b101, 32'd1, 32'd1, 1'b0, 64'h00000001_00000000);
        run_op("msubu_borrow", 3'b111, 32'd1, 32'd1, 1'b0, 64'h00000000_FFFFFFFF);
        run_op("madd_neg", 3'b100, 32'hFFFFFFFE, 32'd3, 1'b0, 64'h00000000_FFFFFFF9);
        run_op("msub", 3'b110, 32'd2, 32'd3, 1'b0, 64'h00000000_FFFFFFF3);
        // mthi in the accept cycle writes a=2 into HI before the accumulate.
        run_op("maddu_mthi_same", 3'b101, 32'd2, 32'd3, 1'b1, 64'h00000002_FFFFFFF9);

        // start/mthi/mtlo with interrupt are all dropped
        h0 = hi; l0 = lo;
        @(negedge clk);
        op = 3'b000; a = 32'd6; b = 32'd7; start = 1'b1; interrupt = 1'b1; mthi = 1'b1; mtlo = 1'b1;
        @(negedge clk);
        start = 1'b0; interrupt = 1'b0; mthi = 1'b0; mtlo = 1'b0;
        chk("intr busy", {63'd0, busy}, 64'd0);
        chk("intr hi", {32'd0, hi}, {32'd0, h0});
        chk("intr lo", {32'd0, lo}, {32'd0, l0});

        // flush in IDLE blocks start but mtlo still lands
        @(negedge clk);
        op = 3'b001; a = 32'h0000ABCD; b = 32'd2; start = 1'b1; flush = 1'b1; mtlo = 1'b1;
        @(negedge clk);
        start = 1'b0; flush = 1'b0; mtlo = 1'b0;
        chk("idle_flush busy", {63'd0, busy}, 64'd0);
        chk("idle_flush lo", {32'd0, lo}, 64'h00000000_0000ABCD);

        // flush on RUN cycle 10
        h0 = hi; l0 = lo; d0 = ndone;
        launch(3'b000, 32'd6, 32'd7, 1'b0);
        repeat (9) @(negedge clk);
        flush = 1'b1;
        @(negedge clk);
        flush = 1'b0;
        chk("flush busy", {63'd0, busy}, 64'd0);
        repeat (40) @(negedge clk);
        chk("flush hi", {32'd0, hi}, {32'd0, h0});
        chk("flush lo", {32'd0, lo}, {32'd0, l0});
        chk("flush done_pulses", ndone - d0, 64'd0);

        // start and mthi while busy are ignored
        mt(1'b1, 32'd0);
        mt(1'b0, 32'd0);
        sb.push_back(64'h00000000_0000002A);
        lbl.push_back("madd_ignore_busy");
        launch(3'b100, 32'd6, 32'd7, 1'b0);
        k = 0;
        repeat (3) begin
            k++;
            @(negedge clk);
        end
        op = 3'b011; a = 32'h00001234; b = 32'd1; start = 1'b1; mthi = 1'b1;
        k++;
        @(negedge clk);
        start = 1'b0; mthi = 1'b0;
        wait_idle(n);
        chk("madd_ignore_busy busy_cycles", k + n, 64'd33);
        repeat (3) @(negedge clk);
        chk("ignored start stays idle", {63'd0, busy}, 64'd0);

        // asynchronous reset mid-divide
        launch(3'b010, 32'd100, 32'd7, 1'b0);
        repeat (14) @(negedge clk);
        #1 reset = 1'b0;
        #1;
        chk("async_reset busy", {63'd0, busy}, 64'd0);
        chk("async_reset hi", {32'd0, hi}, 64'd0);
        chk("async_reset lo", {32'd0, lo}, 64'd0);
        @(negedge clk);
        reset = 1'b1;
        run_op("mult_after_reset", 3'b000, 32'd6, 32'd7, 1'b0, 64'h00000000_0000002A);

        chk("scoreboard empty", sb.size(), 64'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/mult_div_iter.md
# mult_div_iter

Parametrised iterative multiply/divide unit for the EX stage of the pipelined MIPS CPU. It replaces the fixed-latency behavioural HI/LO unit with a shift-add multiplier and restoring divider of configurable width. It adds accumulate/subtract modes (madd/maddu/msub/msubu), a pipeline flush/abort input, and defined divide-by-zero and overflow results. The stall logic reads `busy`; the mfhi/mflo path reads `hi`/`lo`.

## Interface

- `WIDTH`, default 32: operand width and HI/LO register width; must be even and ≥ 4.
- `clk`  in  1  clock, rising-edge active.
- `reset`  in  1  asynchronous, active-low; all state is cleared while 0.
- `a`  in  WIDTH  operand A: multiplicand or dividend; also the mthi/mtlo data.
- `b`  in  WIDTH  operand B: multiplier or divisor.
- `op`  in  3  000 mult, 001 multu, 010 div, 011 divu, 100 madd, 101 maddu, 110 msub, 111 msubu.
- `start`  in  1  launch `op` on `a`/`b`; sampled only when idle.
- `interrupt`  in  1  exception/interrupt taken this cycle; suppresses `start`, `mthi` and `mtlo`.
- `flush`  in  1  abort any in-flight operation.
- `mthi`, `mtlo`  in  1  write `a` into HI or LO; honoured only when idle.
- `busy`  out  1  operation in flight.
- `done`  out  1  one-cycle pulse in the cycle after HI/LO take a result.
- `hi`, `lo`  out  WIDTH  architectural HI/LO registers.

## Operation

- Reset values: `hi`=0, `lo`=0, `busy`=0, `done`=0, FSM=IDLE, iteration counter=0.
- FSM states: IDLE → RUN → FIX → IDLE.
- **IDLE, operation accept.** With `start`=1 and `interrupt`=0, latch the operand magnitudes: |a| and |b| for signed ops, raw values for unsigned ops. Latch the result sign, `op` and counter=WIDTH, then go to RUN.
  - `start` with `interrupt`=1 is dropped.
- **IDLE, register writes.** `mthi`/`mtlo` with `interrupt`=0 write `a` into HI/LO.
  - These writes are allowed in the same cycle as an accepted `start`.
- **RUN.** One iteration per cycle; the counter decrements each cycle and the FSM moves to FIX when the counter reaches 0.
  - Multiply: radix-2 shift-add into a 2·WIDTH partial product.
  - Divide: restoring shift-subtract; quotient bit set when the trial subtraction is non-negative.
- **FIX.** Apply the sign correction and write HI/LO, then return to IDLE.
  - mult/multu: {hi,lo} = product.
  - madd*: {hi,lo} = {hi,lo} + product.
  - msub*: {hi,lo} = {hi,lo} − product.
  - All sums and differences are taken mod 2^(2·WIDTH).
  - madd/msub use HI/LO as they are in FIX, which includes any mthi/mtlo written in the accept cycle.
  - div/divu: lo = quotient, hi = remainder.
  - Signed division truncates toward zero; the remainder takes the sign of the dividend.
- **Divide by zero (b=0).** Runs the full latency, then gives lo = all ones and hi = a (the original operand, unmodified).
- **Signed overflow.** div of a = 1<<(WIDTH−1) by b = all ones gives lo = a, hi = 0.
- **While busy.**
  - `start`, `mthi`, `mtlo` and `interrupt` are ignored.
  - The CPU must stall mult/div/mfhi/mflo/mthi/mtlo while `busy`=1.
- **Flush.** `flush`=1 in RUN or FIX returns the FSM to IDLE on the next edge.
  - HI/LO are unchanged and `done` is not pulsed.
  - Flush in the same cycle as the FIX write wins: no write occurs.
  - `flush` in IDLE also blocks a `start` in the same cycle; `mthi`/`mtlo` still apply.
- **Reset mid-operation.** Asserting `reset` clears everything immediately; no partial result reaches HI/LO.

## Timing

- Let edge T be the edge that accepts `start`.
- `busy` goes to 1 after edge T and stays 1 for WIDTH+1 cycles (RUN ×WIDTH, then FIX ×1).
- HI/LO update at edge T+WIDTH+1. At that same edge `busy` goes to 0 and `done` goes to 1 for one cycle.
- Latency is the same for every `op`: 33 cycles at WIDTH=32.
- A new `start` may be accepted at edge T+WIDTH+2, i.e. in the cycle where `done`=1.
- `mthi`/`mtlo` take effect at the sampling edge. `hi`/`lo` are registered outputs with no combinational path from the inputs.

## Test plan

- Signed multiply, WIDTH=32: mult a=0xFFFFFFFE, b=3 → after 33 cycles hi=0xFFFFFFFF, lo=0xFFFFFFFA. `busy` is high for exactly 33 cycles and `done` pulses once.
- Division: divu 7/2 → lo=3, hi=1. div a=0xFFFFFFF9 (−7), b=2 → lo=0xFFFFFFFD, hi=0xFFFFFFFF.
- Corner cases:
  - div 0x80000000/0xFFFFFFFF → lo=0x80000000, hi=0.
  - divu 5/0 → lo=0xFFFFFFFF, hi=5.
- Accumulate:
  - mthi 0, mtlo 0xFFFFFFFF, then maddu a=1, b=1 → hi=1, lo=0.
  - Then msubu a=1, b=1 → hi=0, lo=0xFFFFFFFF.
- Interrupt and flush:
  - `start` with `interrupt`=1 → `busy` stays 0 and HI/LO are unchanged.
  - mult, then `flush` on cycle 10 of RUN → `busy` drops next cycle, HI/LO keep their prior values, no `done`.
  - `start` and `mthi` issued during `busy` are ignored.
- Reset: deassert `reset`, launch div, assert `reset`=0 at cycle 15 → `busy`, `hi` and `lo` read 0 immediately. After release, mult 6×7 → lo=42, hi=0.
